// File: rtl/host_cmd_decoder.sv
// rtl/host_cmd_decoder.sv - host byte-stream command decoder for the front-end register interface
//
// Parses host frames into register transactions:
//   write: 8'h57, addr, data   read: 8'h52, addr
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   rx_data, rx_valid   received host byte and its one-cycle strobe
//   tx_data, tx_valid,  response byte with valid/ready handshake
//   tx_ready
//   addr, rd_data       read address to the combinational selector and its result
//   wr_data             write data, valid alongside any write strobe
//   dac_we, dac_sel     one-cycle DAC write strobe and DAC index
//   ctrl_reg            control register
//   cnt_clear           one-cycle counter clear pulse (control write with bit 0 set)
//   err                 one-cycle protocol error pulse
//   busy                high whenever a frame or response is in progress
module host_cmd_decoder #(
    parameter logic [7:0] DAC_FIRST = 8'h02,
    parameter logic [7:0] DAC_LAST  = 8'h06,
    parameter logic [7:0] CTRL_ADDR = 8'h01,
    parameter int         TIMEOUT   = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic [7:0] addr,
    input  logic [7:0] rd_data,
    output logic [7:0] wr_data,
    output logic       dac_we,
    output logic [2:0] dac_sel,
    output logic [7:0] ctrl_reg,
    output logic       cnt_clear,
    output logic       err,
    output logic       busy
);

    localparam logic [7:0]  CMD_WR  = 8'h57;
    localparam logic [7:0]  CMD_RD  = 8'h52;
    // Counter value in the last permitted idle cycle of a frame.
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        GET_ADDR,
        GET_DATA,
        RD_WAIT,
        TX_RESP
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        is_write;
    logic [7:0]  wr_addr;
    logic [15:0] tmo_cnt;

    logic        timeout;
    logic        wr_done;
    logic        stray_byte;
    logic        in_frame;
    logic        in_dac;
    logic        in_ctrl;
    logic [7:0]  dac_off;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        timeout    = 1'b0;
        wr_done    = 1'b0;
        stray_byte = 1'b0;
        case (state)
            IDLE: begin
                if (rx_valid && (rx_data == CMD_WR || rx_data == CMD_RD)) begin
                    state_nxt = GET_ADDR;
                end
            end
            GET_ADDR: begin
                // A byte arriving in the expiry cycle still counts.
                if (rx_valid) begin
                    state_nxt = is_write ? GET_DATA : RD_WAIT;
                end else if (tmo_cnt == TO_LAST) begin
                    timeout   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            GET_DATA: begin
                if (rx_valid) begin
                    wr_done   = 1'b1;
                    state_nxt = IDLE;
                end else if (tmo_cnt == TO_LAST) begin
                    timeout   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            RD_WAIT: begin
                stray_byte = rx_valid;
                state_nxt  = TX_RESP;
            end
            TX_RESP: begin
                stray_byte = rx_valid;
                if (tx_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign in_frame = (state == GET_ADDR) || (state == GET_DATA);
    assign in_dac   = (wr_addr >= DAC_FIRST) && (wr_addr <= DAC_LAST);
    assign in_ctrl  = (wr_addr == CTRL_ADDR);
    assign dac_off  = wr_addr - DAC_FIRST;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            is_write  <= 1'b0;
            wr_addr   <= 8'h00;
            tmo_cnt   <= 16'h0000;
            addr      <= 8'h00;
            wr_data   <= 8'h00;
            dac_we    <= 1'b0;
            dac_sel   <= 3'd0;
            ctrl_reg  <= 8'h00;
            cnt_clear <= 1'b0;
            err       <= 1'b0;
            tx_data   <= 8'h00;
            tx_valid  <= 1'b0;
        end else begin
            dac_we    <= 1'b0;
            cnt_clear <= 1'b0;
            err       <= 1'b0;

            // Idle outside a frame; restarts on every accepted byte.
            if (rx_valid || !in_frame) begin
                tmo_cnt <= 16'h0000;
            end else begin
                tmo_cnt <= tmo_cnt + 16'h0001;
            end

            if (state == IDLE && rx_valid) begin
                is_write <= (rx_data == CMD_WR);
            end

            // Writes keep their address private so the selector address is untouched.
            if (state == GET_ADDR && rx_valid) begin
                if (is_write) begin
                    wr_addr <= rx_data;
                end else begin
                    addr <= rx_data;
                end
            end

            if (wr_done) begin
                wr_data <= rx_data;
                if (in_dac) begin
                    dac_we  <= 1'b1;
                    dac_sel <= dac_off[2:0];
                end else if (in_ctrl) begin
                    ctrl_reg  <= rx_data;
                    cnt_clear <= rx_data[0];
                end else begin
                    err <= 1'b1;
                end
            end

            if (timeout || stray_byte) begin
                err <= 1'b1;
            end

            // Selector has had one full cycle to settle on addr.
            if (state == RD_WAIT) begin
                tx_data  <= rd_data;
                tx_valid <= 1'b1;
            end

            if (state == TX_RESP && tx_ready) begin
                tx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_host_cmd_decoder.sv
// tb/tb_host_cmd_decoder.sv - scoreboard testbench for host_cmd_decoder
module tb_host_cmd_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] addr;
    logic [7:0] rd_data;
    logic [7:0] wr_data;
    logic       dac_we;
    logic [2:0] dac_sel;
    logic [7:0] ctrl_reg;
    logic       cnt_clear;
    logic       err;
    logic       busy;

    always #5 clk = ~clk;

    host_cmd_decoder #(
        .DAC_FIRST (8'h02),
        .DAC_LAST  (8'h06),
        .CTRL_ADDR (8'h01),
        .TIMEOUT   (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .addr      (addr),
        .rd_data   (rd_data),
        .wr_data   (wr_data),
        .dac_we    (dac_we),
        .dac_sel   (dac_sel),
        .ctrl_reg  (ctrl_reg),
        .cnt_clear (cnt_clear),
        .err       (err),
        .busy      (busy)
    );

    // Read-data selector model.
    always_comb begin
        rd_data = addr ^ 8'hA5;
        case (addr)
            8'h00: rd_data = 8'h12;
            8'h01: rd_data = ctrl_reg;
            8'h30: rd_data = 8'h3C;
            default: ;
        endcase
    end

    localparam int K_ERR = 0;
    localparam int K_DAC = 1;
    localparam int K_CLR = 2;
    localparam int K_TX  = 3;

    typedef struct {
        int         kind;
        logic [7:0] a;
        logic [7:0] b;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic exp_t mk(input int kind, input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        e.kind = kind;
        e.a    = a;
        e.b    = b;
        return e;
    endfunction

    task automatic expect_evt(input int kind, input logic [7:0] a, input logic [7:0] b);
        q.push_back(mk(kind, a, b));
    endtask

    task automatic check_evt(input string name, input int kind, input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        n_cmp++;
        if (q.size() == 0) begin
            n_bad++;
            $display("FAIL %s: unexpected event a=%02h b=%02h, none required", name, a, b);
        end else begin
            e = q.pop_front();
            if (e.kind != kind || e.a != a || e.b != b) begin
                n_bad++;
                $display("FAIL %s: got kind=%0d a=%02h b=%02h, required kind=%0d a=%02h b=%02h",
                         name, kind, a, b, e.kind, e.a, e.b);
            end
        end
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h, required %02h", name, act, exp);
        end
    endtask

    // Monitor: every strobe or handshake consumes one scoreboard entry.
    always @(negedge clk) begin
        if (!rst) begin
            if (err)                 check_evt("err_pulse", K_ERR, 8'h00, 8'h00);
            if (dac_we)              check_evt("dac_write", K_DAC, {5'b0, dac_sel}, wr_data);
            if (cnt_clear)           check_evt("cnt_clear", K_CLR, 8'h00, wr_data);
            if (tx_valid && tx_ready) check_evt("tx_xfer", K_TX, tx_data, 8'h00);
        end
    end

    // Entered and left at posedge+1; the byte is sampled at the enclosed edge.
    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] held;
        rst      = 1'b1;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        tx_ready = 1'b1;
        idle(3);
        chk("rst_tx_valid", {7'b0, tx_valid}, 8'h00);
        chk("rst_busy",     {7'b0, busy},     8'h00);
        chk("rst_ctrl_reg", ctrl_reg,         8'h00);
        chk("rst_addr",     addr,             8'h00);
        chk("rst_tx_data",  tx_data,          8'h00);
        rst = 1'b0;
        idle(1);

        // DAC writes, including both range ends.
        expect_evt(K_DAC, 8'd2, 8'hA5);
        send(8'h57); send(8'h04); send(8'hA5);
        expect_evt(K_DAC, 8'd0, 8'h3E);
        send(8'h57); send(8'h02); send(8'h3E);
        expect_evt(K_DAC, 8'd4, 8'h81);
        send(8'h57); send(8'h06); send(8'h81);
        idle(1);
        chk("write_keeps_addr", addr, 8'h00);

        // Control writes: clear pulse only with bit 0 set.
        expect_evt(K_CLR, 8'h00, 8'h03);
        send(8'h57); send(8'h01); send(8'h03);
        chk("ctrl_03", ctrl_reg, 8'h03);
        send(8'h57); send(8'h01); send(8'h02);
        chk("ctrl_02", ctrl_reg, 8'h02);

        // Unmapped write addresses.
        expect_evt(K_ERR, 8'h00, 8'h00);
        send(8'h57); send(8'h00); send(8'h11);
        expect_evt(K_ERR, 8'h00, 8'h00);
        send(8'h57); send(8'h30); send(8'h11);
        idle(2);
        chk("ctrl_after_illegal", ctrl_reg, 8'h02);

        // Read with backpressure and a stray byte.
        tx_ready = 1'b0;
        send(8'h52);
        send(8'h30);
        chk("rd_addr_n1",   addr, 8'h30);
        chk("rd_valid_n1",  {7'b0, tx_valid}, 8'h00);
        idle(1);
        chk("rd_valid_n2",  {7'b0, tx_valid}, 8'h01);
        chk("rd_data_n2",   tx_data, 8'h3C);
        held = tx_data;
        expect_evt(K_ERR, 8'h00, 8'h00);
        send(8'h99);
        for (int i = 0; i < 4; i++) begin
            chk("hold_valid", {7'b0, tx_valid}, 8'h01);
            chk("hold_data",  tx_data, held);
            idle(1);
        end
        expect_evt(K_TX, 8'h3C, 8'h00);
        tx_ready = 1'b1;
        idle(1);
        chk("rd_done_valid", {7'b0, tx_valid}, 8'h00);
        chk("rd_done_busy",  {7'b0, busy}, 8'h00);

        // Timeout after 8 idle cycles, then recovery with a read.
        expect_evt(K_ERR, 8'h00, 8'h00);
        send(8'h57);
        idle(7);
        chk("to_busy_before", {7'b0, busy}, 8'h01);
        idle(1);
        chk("to_busy_after",  {7'b0, busy}, 8'h00);
        idle(2);
        expect_evt(K_TX, 8'h12, 8'h00);
        send(8'h52); send(8'h00);
        idle(3);
        chk("version_busy", {7'b0, busy}, 8'h00);

        // Reset while a response is pending.
        tx_ready = 1'b0;
        send(8'h52); send(8'h30);
        idle(1);
        chk("pre_rst_valid", {7'b0, tx_valid}, 8'h01);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        chk("mid_rst_valid", {7'b0, tx_valid}, 8'h00);
        chk("mid_rst_busy",  {7'b0, busy}, 8'h00);
        chk("mid_rst_ctrl",  ctrl_reg, 8'h00);
        chk("mid_rst_addr",  addr, 8'h00);
        tx_ready = 1'b1;
        send(8'hFF);
        idle(3);
        chk("junk_busy", {7'b0, busy}, 8'h00);

        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d events outstanding, required 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/host_cmd_decoder.md
Name: host_cmd_decoder

Overview:
- Host-side command decoder for the front-end register interface.
- Parses the host byte stream into read and write transactions.
- Writes: generates DAC and control write strobes.
- Reads: drives the read-address bus of the combinational read-data selector, captures the selected byte one cycle later and returns it to the host via a valid/ready transmit handshake.
- Sits between the host link byte receiver/transmitter and the register/selector logic.

Parameters:
- DAC_FIRST, 8'h02, first DAC address
- DAC_LAST, 8'h06, last DAC address
- CTRL_ADDR, 8'h01, control register address (read/write)
- TIMEOUT, 1000, max clk cycles between bytes of one frame; range 2..65535

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
rx_data  input  8  received host byte
rx_valid  input  1  one-cycle strobe, rx_data valid
tx_data  output  8  response byte
tx_valid  output  1  response valid; held until accepted
tx_ready  input  1  transmitter accepts tx_data when tx_valid&&tx_ready
addr  output  8  read address to selector
rd_data  input  8  selector output (combinational from addr)
wr_data  output  8  write data, valid with any write strobe
dac_we  output  1  one-cycle DAC write strobe
dac_sel  output  3  DAC index = address - DAC_FIRST
ctrl_reg  output  8  control register
cnt_clear  output  1  one-cycle counter clear pulse
err  output  1  one-cycle protocol error pulse
busy  output  1  high in every state except IDLE

Behaviour:
- Reset (rst=1 at clk edge): state IDLE; all outputs 0 (addr=0, ctrl_reg=0, tx_data=0). Reset mid-frame or mid-response abandons it; tx_valid drops without handshake.
- Frames: write = 8'h57, addr, data. Read = 8'h52, addr.
- States: IDLE, GET_ADDR, GET_DATA, RD_WAIT, TX_RESP.
- IDLE:
  - rx_valid with 8'h57 -> GET_ADDR, write flag set.
  - rx_valid with 8'h52 -> GET_ADDR, read flag set.
  - Any other byte: dropped, no err.
- GET_ADDR on rx_valid:
  - Write: latch address -> GET_DATA.
  - Read: addr<=rx_data -> RD_WAIT.
- GET_DATA on rx_valid:
  - wr_data<=rx_data; -> IDLE.
  - Next cycle, exactly one of:
    - address in DAC_FIRST..DAC_LAST (inclusive): dac_we=1, dac_sel=address-DAC_FIRST.
    - address == CTRL_ADDR: ctrl_reg<=rx_data; cnt_clear=1 if rx_data[0]=1. ctrl_reg updates on the same edge as the strobes.
    - any other address (version 8'h00, counter range, unmapped): err=1.
- RD_WAIT:
  - Lasts exactly one cycle.
  - At its closing edge: tx_data<=rd_data, tx_valid<=1 -> TX_RESP.
  - Read latency: rx_valid of the address byte at cycle N -> tx_valid high from N+2.
- TX_RESP:
  - Hold tx_valid and tx_data stable until a clk edge with tx_ready=1.
  - Following cycle: tx_valid=0, state IDLE.
  - tx_ready may already be high on first assertion: one-cycle tx_valid.
- addr holds its last value after a read; writes do not change addr.
- Bytes in RD_WAIT/TX_RESP: dropped, err=1 next cycle, state unaffected.
- Timeout:
  - 16-bit inter-byte counter, cleared on entry to GET_ADDR/GET_DATA and on each accepted byte.
  - Reaching TIMEOUT cycles without rx_valid -> IDLE, err=1, no strobes.
  - No timeout in RD_WAIT/TX_RESP.
- Strobes: dac_we, cnt_clear and err are single-cycle pulses, registered.
- Simultaneous rx_valid and timeout expiry in the same cycle: byte wins, counter clears.
- Back-to-back frames: a new command byte is accepted in the cycle IDLE is re-entered.

Test Plan:
- Write DAC: bytes 57,04,A5 -> one-cycle dac_we, dac_sel=2, wr_data=A5, err=0; bytes 57,02,xx -> dac_sel=0; bytes 57,06,xx -> dac_sel=4.
- Write control: bytes 57,01,03 -> ctrl_reg=03, cnt_clear pulse. Bytes 57,01,02 -> ctrl_reg=02, no cnt_clear.
- Illegal write: bytes 57,00,11 and 57,30,11 -> err pulse each, no dac_we, ctrl_reg unchanged.
- Read with backpressure:
  - Bytes 52,30, selector model returns 8'h3C -> addr=30 at N+1, tx_valid at N+2, tx_data=3C.
  - Hold tx_ready=0 for 5 cycles: tx_valid/tx_data stable.
  - tx_ready=1 -> single transfer, then IDLE.
  - A byte injected during the wait -> err pulse, response unaffected.
- Timeout and recovery: TIMEOUT=8; byte 57 then 8 idle cycles -> err, IDLE. Then bytes 52,00 with version 8'h12 -> tx_data=12.
- Reset mid-response: rst asserted while tx_valid=1 -> next cycle tx_valid=0, busy=0, ctrl_reg=0, addr=0. Junk byte 8'hFF in IDLE -> ignored, no err.
